// File: rtl/imm_load_sequencer.sv
// rtl/imm_load_sequencer.sv - sequences the shared immediate extender and issues one register-file write per immediate instruction
module imm_load_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [3:0]  immHigh,
    output logic [3:0]  immLow,
    input  logic [15:0] imm_sign_extended,
    input  logic [15:0] zero_extended_value,
    input  logic [15:0] left_shifted_value,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        err_illegal,
    output logic        err_orphan
);

    localparam logic [3:0] OPC_LDIS = 4'h1;
    localparam logic [3:0] OPC_LDIZ = 4'h2;
    localparam logic [3:0] OPC_LUI  = 4'h3;
    localparam logic [3:0] OPC_ORI  = 4'h4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRIVE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_WRITE   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  opc_q, opc_d;
    logic [3:0]  rd_q, rd_d;
    logic [3:0]  imm_high_q, imm_high_d;
    logic [3:0]  imm_low_q, imm_low_d;
    logic [15:0] held_upper_q, held_upper_d;
    logic [3:0]  held_rd_q, held_rd_d;
    logic        lui_pending_q, lui_pending_d;
    logic        rf_we_q, rf_we_d;
    logic [3:0]  rf_waddr_q, rf_waddr_d;
    logic [15:0] rf_wdata_q, rf_wdata_d;
    logic        err_illegal_q, err_illegal_d;
    logic        err_orphan_q, err_orphan_d;
    logic        opc_legal;

    assign opc_legal = (instr[15:12] == OPC_LDIS) || (instr[15:12] == OPC_LDIZ) ||
                       (instr[15:12] == OPC_LUI)  || (instr[15:12] == OPC_ORI);

    assign instr_ready = (state_q == S_IDLE);
    assign immHigh     = imm_high_q;
    assign immLow      = imm_low_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    // Strobes are masked by reset so an aborted instruction never reaches the register file.
    assign rf_we       = rf_we_q & ~rst;
    assign err_illegal = err_illegal_q & ~rst;
    assign err_orphan  = err_orphan_q & ~rst;

    // Next-state logic: accept, drive nibbles, capture extender result, then write.
    always_comb begin
        state_d       = state_q;
        opc_d         = opc_q;
        rd_d          = rd_q;
        imm_high_d    = imm_high_q;
        imm_low_d     = imm_low_q;
        held_upper_d  = held_upper_q;
        held_rd_d     = held_rd_q;
        lui_pending_d = lui_pending_q;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        err_illegal_d = 1'b0;
        err_orphan_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (opc_legal) begin
                        opc_d      = instr[15:12];
                        rd_d       = instr[11:8];
                        imm_high_d = instr[7:4];
                        imm_low_d  = instr[3:0];
                        state_d    = S_DRIVE;
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
            S_DRIVE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d    = S_WRITE;
                rf_we_d    = 1'b1;
                rf_waddr_d = rd_q;
                case (opc_q)
                    OPC_LDIS: begin
                        rf_wdata_d    = imm_sign_extended;
                        lui_pending_d = 1'b0;
                    end
                    OPC_LDIZ: begin
                        rf_wdata_d    = zero_extended_value;
                        lui_pending_d = 1'b0;
                    end
                    OPC_LUI: begin
                        rf_wdata_d    = left_shifted_value;
                        held_upper_d  = left_shifted_value;
                        held_rd_d     = rd_q;
                        lui_pending_d = 1'b1;
                    end
                    default: begin
                        // ORI: combine only with a pending LUI aimed at the same register.
                        if (lui_pending_q && (held_rd_q == rd_q)) begin
                            rf_wdata_d    = held_upper_q | zero_extended_value;
                            lui_pending_d = 1'b0;
                        end else begin
                            rf_wdata_d   = zero_extended_value;
                            err_orphan_d = 1'b1;
                        end
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            opc_q         <= 4'h0;
            rd_q          <= 4'h0;
            imm_high_q    <= 4'h0;
            imm_low_q     <= 4'h0;
            held_upper_q  <= 16'h0000;
            held_rd_q     <= 4'h0;
            lui_pending_q <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= 4'h0;
            rf_wdata_q    <= 16'h0000;
            err_illegal_q <= 1'b0;
            err_orphan_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            opc_q         <= opc_d;
            rd_q          <= rd_d;
            imm_high_q    <= imm_high_d;
            imm_low_q     <= imm_low_d;
            held_upper_q  <= held_upper_d;
            held_rd_q     <= held_rd_d;
            lui_pending_q <= lui_pending_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            err_illegal_q <= err_illegal_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

endmodule
